// File: rtl/sipo_pkg.sv
// Shared constants and helpers for the SIPO receiver.
package sipo_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  // Width of the bit counter for a given word width (never below 1 bit).
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/sipo_stage.sv
// One storage bit with load enable and asynchronous clear.
module sipo_stage (
  input  logic clk,
  input  logic clear,
  input  logic en,
  input  logic d,
  output logic q
);

  // Load d when enabled; clear forces 0 immediately.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      q <= 1'b0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/sipo_rx.sv
// Serial-in, parallel-out receiver: frames WIDTH-bit words and hands them
// over through a valid/ack holding register with a sticky overrun flag.
module sipo_rx
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                       clk,
  input  logic                       clear,
  input  logic                       shift_en,
  input  logic                       serial_in,
  input  logic                       sync,
  output logic [0:WIDTH-1]           data_out,
  output logic                       word_valid,
  input  logic                       word_ack,
  output logic                       overrun,
  output logic [cnt_width(WIDTH)-1:0] bit_count
);

  localparam int unsigned     CntW    = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  // sr_d is the full word as it stands after this edge's shift: the newest
  // bit sits at index 0 and the oldest at WIDTH-1. Only WIDTH-1 bits of
  // history need storing; the newest bit comes straight from serial_in.
  logic [0:WIDTH-2] sr_q;
  logic [0:WIDTH-1] sr_d;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            valid_q, valid_d;
  logic            ovr_q, ovr_d;
  logic            complete;
  logic            accept;

  assign sr_d = {serial_in, sr_q};

  for (genvar i = 0; i < WIDTH - 1; i++) begin : g_sr
    sipo_stage u_sr (
      .clk   (clk),
      .clear (clear),
      .en    (shift_en),
      .d     (sr_d[i]),
      .q     (sr_q[i])
    );
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_out
    sipo_stage u_out (
      .clk   (clk),
      .clear (clear),
      .en    (accept),
      .d     (sr_d[i]),
      .q     (data_out[i])
    );
  end

  // A word completes on the enabled edge that samples the last bit; sync
  // restarts framing, so it never completes a word.
  always_comb begin
    complete = shift_en && !sync && (cnt_q == LastBit);
    accept   = complete && (!valid_q || word_ack);
  end

  // Bit counter next state: sync restarts at 0, counting this edge's bit.
  always_comb begin
    cnt_d = cnt_q;
    if (sync) begin
      cnt_d = shift_en ? CntW'(1) : '0;
    end else if (shift_en) begin
      cnt_d = (cnt_q == LastBit) ? '0 : cnt_q + CntW'(1);
    end
  end

  // Handshake flags: accept sets valid, a lone ack clears it, a dropped word
  // sets the sticky overrun.
  always_comb begin
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (accept) begin
      valid_d = 1'b1;
    end else if (word_ack && valid_q) begin
      valid_d = 1'b0;
    end
    if (complete && !accept) begin
      ovr_d = 1'b1;
    end
  end

  // Counter and flag registers.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      cnt_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bit_count  = cnt_q;
  assign word_valid = valid_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_sipo_rx.sv
// Directed, table-driven bench for sipo_rx with WIDTH=4.
module tb_sipo_rx;

  logic       clk = 1'b0;
  logic       clear;
  logic       shift_en;
  logic       serial_in;
  logic       sync;
  logic [0:3] data_out;
  logic       word_valid;
  logic       word_ack;
  logic       overrun;
  logic [1:0] bit_count;

  int n_cmp = 0;
  int n_bad = 0;

  sipo_rx #(
    .WIDTH (4)
  ) dut (
    .clk        (clk),
    .clear      (clear),
    .shift_en   (shift_en),
    .serial_in  (serial_in),
    .sync       (sync),
    .data_out   (data_out),
    .word_valid (word_valid),
    .word_ack   (word_ack),
    .overrun    (overrun),
    .bit_count  (bit_count)
  );

  always #5 clk = ~clk;

  // One cycle of inputs and the outputs expected after its rising edge.
  // dat is written as data_out[0:3] left to right.
  typedef struct {
    logic       se;
    logic       si;
    logic       sy;
    logic       ack;
    logic [3:0] dat;
    logic       v;
    logic       o;
    logic [1:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic se, logic si, logic sy, logic ack,
                              logic [3:0] dat, logic v, logic o, logic [1:0] cnt);
    vec_t r;
    r.se = se; r.si = si; r.sy = sy; r.ack = ack;
    r.dat = dat; r.v = v; r.o = o; r.cnt = cnt;
    return r;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input int idx, input logic [3:0] dat, input logic v,
                           input logic o, input logic [1:0] cnt);
    check("data_out", idx, 32'(data_out), 32'(dat));
    check("word_valid", idx, 32'(word_valid), 32'(v));
    check("overrun", idx, 32'(overrun), 32'(o));
    check("bit_count", idx, 32'(bit_count), 32'(cnt));
  endtask

  task automatic step(input logic se, input logic si, input logic sy, input logic ack);
    @(negedge clk);
    shift_en = se; serial_in = si; sync = sy; word_ack = ack;
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear = 1'b1; shift_en = 1'b0; serial_in = 1'b0; sync = 1'b0; word_ack = 1'b0;
    #2;
    check_all(-1, 4'b0000, 1'b0, 1'b0, 2'd0);
    @(negedge clk);
    clear = 1'b0;

    // Complete a word so data_out is non-zero, then clear mid-word.
    step(1, 0, 0, 0); step(1, 1, 0, 0); step(1, 1, 0, 0); step(1, 1, 0, 0);
    check_all(-2, 4'b1110, 1'b1, 1'b0, 2'd0);
    step(1, 1, 0, 0); step(1, 0, 0, 0);
    check("bit_count", -3, 32'(bit_count), 32'd2);
    @(negedge clk);
    shift_en = 1'b0;
    #2;
    clear = 1'b1;
    #1;
    check_all(-4, 4'b0000, 1'b0, 1'b0, 2'd0);
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;

    //                 se si sy ack  dat      v  o  cnt
    // 1,0,1,1 right after clear
    vecs.push_back(mk(1, 1, 0, 0, 4'b0000, 0, 0, 2'd1));
    vecs.push_back(mk(1, 0, 0, 0, 4'b0000, 0, 0, 2'd2));
    vecs.push_back(mk(1, 1, 0, 0, 4'b0000, 0, 0, 2'd3));
    vecs.push_back(mk(1, 1, 0, 0, 4'b1101, 1, 0, 2'd0));
    // plain ack, then ack while idle
    vecs.push_back(mk(0, 0, 0, 1, 4'b1101, 0, 0, 2'd0));
    vecs.push_back(mk(0, 0, 0, 1, 4'b1101, 0, 0, 2'd0));
    // streaming 0,1,1,0 then 1,1,0,0 with ack on the second completion edge
    vecs.push_back(mk(1, 0, 0, 0, 4'b1101, 0, 0, 2'd1));
    vecs.push_back(mk(1, 1, 0, 0, 4'b1101, 0, 0, 2'd2));
    vecs.push_back(mk(1, 1, 0, 0, 4'b1101, 0, 0, 2'd3));
    vecs.push_back(mk(1, 0, 0, 0, 4'b0110, 1, 0, 2'd0));
    vecs.push_back(mk(1, 1, 0, 0, 4'b0110, 1, 0, 2'd1));
    vecs.push_back(mk(1, 1, 0, 0, 4'b0110, 1, 0, 2'd2));
    vecs.push_back(mk(1, 0, 0, 0, 4'b0110, 1, 0, 2'd3));
    vecs.push_back(mk(1, 0, 0, 1, 4'b0011, 1, 0, 2'd0));
    vecs.push_back(mk(0, 0, 0, 1, 4'b0011, 0, 0, 2'd0));
    // gapped 1,0,1,1 with junk on serial_in during gaps
    vecs.push_back(mk(1, 1, 0, 0, 4'b0011, 0, 0, 2'd1));
    vecs.push_back(mk(0, 0, 0, 0, 4'b0011, 0, 0, 2'd1));
    vecs.push_back(mk(1, 0, 0, 0, 4'b0011, 0, 0, 2'd2));
    vecs.push_back(mk(0, 1, 0, 0, 4'b0011, 0, 0, 2'd2));
    vecs.push_back(mk(0, 0, 0, 0, 4'b0011, 0, 0, 2'd2));
    vecs.push_back(mk(1, 1, 0, 0, 4'b0011, 0, 0, 2'd3));
    vecs.push_back(mk(0, 0, 0, 0, 4'b0011, 0, 0, 2'd3));
    vecs.push_back(mk(1, 1, 0, 0, 4'b1101, 1, 0, 2'd0));
    vecs.push_back(mk(0, 0, 0, 1, 4'b1101, 0, 0, 2'd0));
    // two bits, then sync with bit 1, then 0,0,1
    vecs.push_back(mk(1, 0, 0, 0, 4'b1101, 0, 0, 2'd1));
    vecs.push_back(mk(1, 0, 0, 0, 4'b1101, 0, 0, 2'd2));
    vecs.push_back(mk(1, 1, 1, 0, 4'b1101, 0, 0, 2'd1));
    vecs.push_back(mk(1, 0, 0, 0, 4'b1101, 0, 0, 2'd2));
    vecs.push_back(mk(1, 0, 0, 0, 4'b1101, 0, 0, 2'd3));
    vecs.push_back(mk(1, 1, 0, 0, 4'b1001, 1, 0, 2'd0));
    vecs.push_back(mk(0, 0, 0, 1, 4'b1001, 0, 0, 2'd0));
    // overrun: 1,0,0,0 unacked, then 1,1,1,1 dropped
    vecs.push_back(mk(1, 1, 0, 0, 4'b1001, 0, 0, 2'd1));
    vecs.push_back(mk(1, 0, 0, 0, 4'b1001, 0, 0, 2'd2));
    vecs.push_back(mk(1, 0, 0, 0, 4'b1001, 0, 0, 2'd3));
    vecs.push_back(mk(1, 0, 0, 0, 4'b0001, 1, 0, 2'd0));
    vecs.push_back(mk(1, 1, 0, 0, 4'b0001, 1, 0, 2'd1));
    vecs.push_back(mk(1, 1, 0, 0, 4'b0001, 1, 0, 2'd2));
    vecs.push_back(mk(1, 1, 0, 0, 4'b0001, 1, 0, 2'd3));
    vecs.push_back(mk(1, 1, 0, 0, 4'b0001, 1, 1, 2'd0));
    vecs.push_back(mk(0, 0, 0, 1, 4'b0001, 0, 1, 2'd0));
    vecs.push_back(mk(0, 0, 0, 1, 4'b0001, 0, 1, 2'd0));
    // overrun stays set across a later accepted word 0,1,0,0
    vecs.push_back(mk(1, 0, 0, 0, 4'b0001, 0, 1, 2'd1));
    vecs.push_back(mk(1, 1, 0, 0, 4'b0001, 0, 1, 2'd2));
    vecs.push_back(mk(1, 0, 0, 0, 4'b0001, 0, 1, 2'd3));
    vecs.push_back(mk(1, 0, 0, 0, 4'b0010, 1, 1, 2'd0));
    // sync without shift_en restarts the count at 0
    vecs.push_back(mk(1, 1, 0, 0, 4'b0010, 1, 1, 2'd1));
    vecs.push_back(mk(0, 0, 1, 0, 4'b0010, 1, 1, 2'd0));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].se, vecs[i].si, vecs[i].sy, vecs[i].ack);
      check_all(i, vecs[i].dat, vecs[i].v, vecs[i].o, vecs[i].cnt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
